// File: rtl/laser500_mem_pkg.sv
// Shared types and defaults for the Laser 500 SDRAM arbiter.
package laser500_mem_pkg;
  localparam int ADDR_W         = 25;
  localparam int LATENCY_DEF    = 2;
  localparam int STARVE_MAX_DEF = 3;

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_DONE} arb_state_t;
  typedef enum logic [1:0] {RID_NONE, RID_DIO, RID_VID, RID_CPU} req_id_t;
endpackage

// File: rtl/laser500_mem_arbiter.sv
// Three-way SDRAM arbiter (download > video > CPU) with CPU anti-starvation
// and a fixed-latency single-access FSM.
module laser500_mem_arbiter
  import laser500_mem_pkg::*;
#(
  parameter int LATENCY    = LATENCY_DEF,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic              F14M,
  input  logic              RESET_n,
  input  logic              dio_req,
  input  logic [ADDR_W-1:0] dio_addr,
  input  logic [7:0]        dio_data,
  output logic              dio_ack,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic [7:0]        vid_data,
  output logic              vid_ack,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [7:0]        cpu_din,
  output logic [7:0]        cpu_dout,
  output logic              cpu_ack,
  output logic              cpu_wait_n,
  output logic [ADDR_W-1:0] sd_addr,
  output logic [7:0]        sd_din,
  output logic              sd_we,
  output logic              sd_oe,
  input  logic [7:0]        sd_dout
);
  localparam logic [2:0] WAIT_LAST  = (LATENCY > 1) ? 3'(LATENCY - 2) : 3'd0;
  localparam logic [1:0] STARVE_LIM = 2'(STARVE_MAX);

  arb_state_t state;
  req_id_t    owner;
  req_id_t    pick;
  logic [2:0] wcnt;
  logic [1:0] starve;
  logic       acc_we;
  logic       bus_end;

  // CPU jumps ahead of video only once video has starved it long enough.
  always_comb begin
    pick = RID_NONE;
    if (dio_req)                                         pick = RID_DIO;
    else if (cpu_req && (!vid_req || starve == STARVE_LIM)) pick = RID_CPU;
    else if (vid_req)                                    pick = RID_VID;
  end

  assign bus_end = (state == ST_ISSUE && LATENCY == 1) ||
                   (state == ST_WAIT && wcnt == WAIT_LAST);

  assign cpu_wait_n = ~(cpu_req & ~cpu_ack);

  always_ff @(posedge F14M or negedge RESET_n) begin
    if (!RESET_n) begin
      state    <= ST_IDLE;
      owner    <= RID_NONE;
      wcnt     <= '0;
      starve   <= '0;
      acc_we   <= 1'b0;
      dio_ack  <= 1'b0;
      vid_ack  <= 1'b0;
      cpu_ack  <= 1'b0;
      vid_data <= '0;
      cpu_dout <= '0;
      sd_addr  <= '0;
      sd_din   <= '0;
      sd_we    <= 1'b0;
      sd_oe    <= 1'b0;
    end else begin
      dio_ack <= 1'b0;
      vid_ack <= 1'b0;
      cpu_ack <= 1'b0;
      if (bus_end) begin
        sd_oe   <= 1'b0;
        sd_we   <= 1'b0;
        sd_addr <= '0;
        sd_din  <= '0;
      end
      case (state)
        ST_IDLE: if (pick != RID_NONE) begin
          state <= ST_ISSUE;
          owner <= pick;
          sd_oe <= 1'b1;
          case (pick)
            RID_DIO: begin
              sd_addr <= dio_addr;
              sd_din  <= dio_data;
              sd_we   <= 1'b1;
              acc_we  <= 1'b1;
            end
            RID_VID: begin
              sd_addr <= vid_addr;
              sd_din  <= '0;
              sd_we   <= 1'b0;
              acc_we  <= 1'b0;
              if (cpu_req && starve != 2'd3) starve <= starve + 2'd1;
            end
            RID_CPU: begin
              sd_addr <= cpu_addr;
              sd_din  <= cpu_din;
              sd_we   <= cpu_we;
              acc_we  <= cpu_we;
              starve  <= '0;
            end
            default: ;
          endcase
        end
        ST_ISSUE: begin
          wcnt  <= '0;
          state <= (LATENCY == 1) ? ST_DONE : ST_WAIT;
        end
        ST_WAIT: begin
          if (wcnt == WAIT_LAST) state <= ST_DONE;
          else                   wcnt  <= wcnt + 3'd1;
        end
        ST_DONE: begin
          state <= ST_IDLE;
          owner <= RID_NONE;
          case (owner)
            RID_DIO: dio_ack <= 1'b1;
            RID_VID: begin
              vid_ack  <= 1'b1;
              vid_data <= sd_dout;
            end
            RID_CPU: begin
              cpu_ack <= 1'b1;
              if (!acc_we) cpu_dout <= sd_dout;
            end
            default: ;
          endcase
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_laser500_mem_arbiter.sv
// Scoreboard bench for laser500_mem_arbiter with a behavioural SDRAM model.
module tb_laser500_mem_arbiter;
  logic        F14M = 1'b0;
  logic        RESET_n;
  logic        dio_req, vid_req, cpu_req, cpu_we;
  logic [24:0] dio_addr, vid_addr, cpu_addr, sd_addr;
  logic [7:0]  dio_data, cpu_din, vid_data, cpu_dout, sd_din, sd_dout;
  logic        dio_ack, vid_ack, cpu_ack, cpu_wait_n, sd_we, sd_oe;

  int n_chk = 0;
  int n_err = 0;

  typedef struct {int id; bit rd; logic [7:0] data;} exp_t;
  exp_t sb[$];
  logic [7:0] sd_mem [int];

  laser500_mem_arbiter dut (
    .F14M(F14M), .RESET_n(RESET_n),
    .dio_req(dio_req), .dio_addr(dio_addr), .dio_data(dio_data), .dio_ack(dio_ack),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_data(vid_data), .vid_ack(vid_ack),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
    .cpu_dout(cpu_dout), .cpu_ack(cpu_ack), .cpu_wait_n(cpu_wait_n),
    .sd_addr(sd_addr), .sd_din(sd_din), .sd_we(sd_we), .sd_oe(sd_oe), .sd_dout(sd_dout)
  );

  always #5 F14M = ~F14M;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [7:0] pat(input logic [24:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  function automatic logic [7:0] exp_rd(input logic [24:0] a);
    return (a == 25'h0004000) ? 8'hA5 : pat(a);
  endfunction

  task automatic push(input int id, input bit rd, input logic [7:0] data);
    exp_t e;
    e.id = id; e.rd = rd; e.data = data;
    sb.push_back(e);
  endtask

  // SDRAM model: data valid one cycle after the last cycle of oe
  always @(posedge F14M) begin
    if (sd_oe && sd_we) sd_mem[int'(sd_addr)] = sd_din;
    if (sd_oe && !sd_we)
      sd_dout <= sd_mem.exists(int'(sd_addr)) ? sd_mem[int'(sd_addr)] : pat(sd_addr);
  end

  always @(negedge F14M) begin
    if (RESET_n === 1'b1) begin
      int n, id;
      logic [7:0] d;
      exp_t e;
      n  = int'(dio_ack) + int'(vid_ack) + int'(cpu_ack);
      id = dio_ack ? 1 : vid_ack ? 2 : cpu_ack ? 3 : 0;
      d  = vid_ack ? vid_data : cpu_dout;
      if (n > 1) chk("multi_ack", n, 1);
      if (n > 0) begin
        if (sb.size() == 0) chk("unexp_ack", id, 0);
        else begin
          e = sb.pop_front();
          chk("ack_id", id, e.id);
          if (e.rd) chk("rd_data", d, e.data);
        end
      end
    end
  end

  task automatic hold_until(input int which, input int budget);
    bit done = 0;
    for (int i = 0; i < budget && !done; i++) begin
      @(posedge F14M); #1;
      case (which)
        1: if (dio_ack) begin dio_req = 0; done = 1; end
        2: if (vid_ack) begin vid_req = 0; done = 1; end
        default: if (cpu_ack) begin cpu_req = 0; done = 1; end
      endcase
    end
    if (!done) begin
      chk("ack_timeout", 0, which);
      case (which)
        1: dio_req = 0;
        2: vid_req = 0;
        default: cpu_req = 0;
      endcase
    end
  endtask

  task automatic starve_round();
    push(2, 1, exp_rd(25'h200)); push(2, 1, exp_rd(25'h200));
    push(2, 1, exp_rd(25'h200)); push(3, 1, exp_rd(25'h300));
    vid_addr = 25'h200; vid_req = 1;
    cpu_addr = 25'h300; cpu_we = 0; cpu_req = 1;
    hold_until(3, 80);
    push(2, 1, exp_rd(25'h200));
    hold_until(2, 20);
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int nd;
    RESET_n = 0;
    dio_req = 0; vid_req = 0; cpu_req = 0; cpu_we = 0;
    dio_addr = '0; vid_addr = '0; cpu_addr = '0; dio_data = '0; cpu_din = '0;
    sd_dout = '0;
    sd_mem[32'h4000] = 8'hA5;
    #23;
    chk("rst_oe", sd_oe, 0);
    chk("rst_we", sd_we, 0);
    chk("rst_addr", sd_addr, 0);
    chk("rst_acks", {dio_ack, vid_ack, cpu_ack}, 0);
    chk("rst_vdata", vid_data, 0);
    chk("rst_cdout", cpu_dout, 0);
    @(negedge F14M); RESET_n = 1;
    repeat (2) @(posedge F14M);
    #1;

    // single CPU read, cycle-exact
    cpu_addr = 25'h0004000; cpu_we = 0; cpu_req = 1;
    push(3, 1, 8'hA5);
    #1 chk("rd_waitn_pre", cpu_wait_n, 0);
    for (int i = 1; i <= 4; i++) begin
      @(posedge F14M); #1;
      if (i <= 2) begin
        chk("rd_oe", sd_oe, 1);
        chk("rd_we", sd_we, 0);
        chk("rd_addr", sd_addr, 25'h0004000);
        chk("rd_waitn", cpu_wait_n, 0);
      end else if (i == 3) begin
        chk("rd_oe_done", sd_oe, 0);
        chk("rd_ack_early", cpu_ack, 0);
        chk("rd_waitn", cpu_wait_n, 0);
      end else begin
        chk("rd_ack", cpu_ack, 1);
        chk("rd_dout", cpu_dout, 8'hA5);
        chk("rd_waitn_rel", cpu_wait_n, 1);
        cpu_req = 0;
      end
    end
    repeat (3) @(posedge F14M);
    #1;

    // simultaneous requests: dio, then vid, then cpu
    push(1, 0, 8'h00); push(2, 1, exp_rd(25'h200)); push(3, 1, exp_rd(25'h300));
    dio_addr = 25'h100; dio_data = 8'h3C; dio_req = 1;
    vid_addr = 25'h200; vid_req = 1;
    cpu_addr = 25'h300; cpu_we = 0; cpu_req = 1;
    fork
      hold_until(1, 40);
      hold_until(2, 40);
      hold_until(3, 40);
    join
    chk("dio_write", sd_mem.exists(32'h100) ? {24'h0, sd_mem[32'h100]} : 32'hFFFF, 32'h3C);
    repeat (3) @(posedge F14M);
    #1;

    // video hog: three video grants then CPU; twice to show the count cleared
    starve_round();
    repeat (2) @(posedge F14M);
    #1;
    starve_round();
    repeat (3) @(posedge F14M);
    #1;

    // download blocks CPU entirely
    push(1, 0, 8'h00); push(1, 0, 8'h00); push(1, 0, 8'h00);
    dio_addr = 25'h500; dio_data = 8'h11; dio_req = 1;
    cpu_addr = 25'h300; cpu_we = 0; cpu_req = 1;
    nd = 0;
    for (int i = 0; i < 60 && nd < 3; i++) begin
      @(posedge F14M); #1;
      chk("dio_block_waitn", cpu_wait_n, 0);
      if (dio_ack) begin
        nd++;
        if (nd == 3) dio_req = 0;
      end
    end
    if (nd < 3) begin
      chk("dio_block_count", nd, 3);
      dio_req = 0;
    end
    push(3, 1, exp_rd(25'h300));
    hold_until(3, 20);
    chk("waitn_after", cpu_wait_n, 1);
    repeat (3) @(posedge F14M);
    #1;

    // address change after grant must not reach SDRAM
    cpu_addr = 25'h700; cpu_we = 0; cpu_req = 1;
    push(3, 1, exp_rd(25'h700));
    @(posedge F14M); #1;
    chk("lat_addr_issue", sd_addr, 25'h700);
    cpu_addr = 25'h7FF;
    @(posedge F14M); #1;
    chk("lat_addr_wait", sd_addr, 25'h700);
    hold_until(3, 20);
    repeat (3) @(posedge F14M);
    #1;

    // reset in WAIT of a CPU write aborts it
    cpu_addr = 25'h600; cpu_din = 8'h77; cpu_we = 1; cpu_req = 1;
    @(posedge F14M); #1;
    chk("wr_we", sd_we, 1);
    @(posedge F14M); #1;
    RESET_n = 0;
    #1;
    chk("abort_oe", sd_oe, 0);
    chk("abort_we", sd_we, 0);
    chk("abort_addr", sd_addr, 0);
    chk("abort_din", sd_din, 0);
    chk("abort_ack", cpu_ack, 0);
    chk("abort_cdout", cpu_dout, 0);
    chk("abort_vdata", vid_data, 0);
    cpu_req = 0; cpu_we = 0;
    repeat (2) @(posedge F14M);
    @(negedge F14M); RESET_n = 1;
    repeat (6) @(posedge F14M);
    #1;
    cpu_addr = 25'h800; cpu_we = 0; cpu_req = 1;
    push(3, 1, exp_rd(25'h800));
    @(posedge F14M); #1;
    chk("regrant_oe", sd_oe, 1);
    chk("regrant_addr", sd_addr, 25'h800);
    hold_until(3, 20);
    repeat (4) @(posedge F14M);
    #1;

    chk("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
